npm_toggle_phy_step_arbiter: RTL and testbench
==============================================

NPM_TOGGLE_PHY_STEP_ARBITER -- requirements
Module: npm_toggle_phy_step_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 10'd1023, giving the max RUN cycles before abort; legal range 1..1023.
REQ-002 SHALL have port iSystemClock  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port iReset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port iCMDValid  in  1  step request valid.
REQ-005 SHALL have port iCMDStep  in  2  step index: 0 buffer-reset, 1 DQS-ready, 2 data-in, 3 data-out.
REQ-006 SHALL have port oCMDReady  out  1  request accepted when iCMDValid & oCMDReady.
REQ-007 SHALL have port oStart  out  4  one-hot start pulse to the step primitives.
REQ-008 SHALL have port iStepLast  in  4  per-step oLastStep from the primitives.
REQ-009 SHALL have ports iPI_BUFF_Reset, iPI_BUFF_RE, iPI_BUFF_WE, iDQSOutEnable  in  4 each  per-step controls, bit n = step n.
REQ-010 SHALL have port iPO_DQStrobe  in  32  per-step strobe, bits [8n+7:8n] = step n.
REQ-011 SHALL have ports oPI_BUFF_Reset, oPI_BUFF_RE, oPI_BUFF_WE, oDQSOutEnable  out  1 each, and oPO_DQStrobe  out  8  muxed PHY controls.
REQ-012 SHALL have port oOwner  out  4  one-hot active step; 0 when idle.
REQ-013 SHALL have port oDone  out  1  one-cycle pulse on step completion.
REQ-014 SHALL have port oTimeout  out  1  one-cycle pulse on step abort.

Function
REQ-015 SHALL use a one-hot FSM with states RESET, READY, START, RUN and ABORT.
REQ-016 SHALL always move RESET->READY after one cycle.
REQ-017 SHALL, in READY, drive oCMDReady=1; on iCMDValid it SHALL latch iCMDStep into rSel and go to START.
REQ-018 SHALL, in START, drive oStart = (1<<rSel) for exactly one cycle, clear the timer, and go to RUN.
REQ-019 SHALL, in RUN, keep oStart=0, increment the 10-bit timer each cycle, and watch only iStepLast[rSel]; other iStepLast bits are ignored.
REQ-020 SHALL, on iStepLast[rSel] in RUN, pulse oDone and drive oCMDReady=1 in that same cycle.
REQ-021 SHALL, on that completion cycle, go to START with the new rSel if iCMDValid=1 (back-to-back, no idle cycle), else go to READY.
REQ-022 SHALL, when the timer reaches TIMEOUT_CYCLES in RUN without iStepLast[rSel], go to ABORT.
REQ-023 SHALL, if iStepLast[rSel] and the timeout coincide, treat the cycle as completion, not abort.
REQ-024 SHALL, in ABORT, pulse oTimeout for one cycle, drive the idle values of REQ-027, and go to READY; oCMDReady=0 in ABORT.
REQ-025 SHALL drive oCMDReady=0 in RESET, START and RUN, except the completion cycle of REQ-020.
REQ-026 SHALL, in START and RUN, pass the rSel slice of every iPI_*, iDQSOutEnable and iPO_DQStrobe combinationally to the outputs, with oOwner = 1<<rSel.
REQ-027 SHALL, in RESET, READY and ABORT, drive idle values: all oPI_BUFF_* = 0, oPO_DQStrobe = 8'h00, oDQSOutEnable = 1, oOwner = 0.
REQ-028 SHALL keep rSel stable from START until the next acceptance.
REQ-029 SHALL keep the timer from wrapping; it saturates at TIMEOUT_CYCLES.

Reset
REQ-030 SHALL, on iReset assertion, go to RESET immediately, including mid-step.
REQ-031 SHALL, during reset, drive oStart=0, oCMDReady=0, oDone=0, oTimeout=0, oOwner=0, all oPI_BUFF_*=0, oPO_DQStrobe=0, oDQSOutEnable=0, rSel=0 and timer=0.
REQ-032 SHALL accept no request in the first cycle after reset release; READY is reached on the second clock edge.

Verification
REQ-033 SHALL cover single step: iCMDStep=0, iStepLast[0] 64 cycles after oStart -> oStart=4'b0001 one cycle, oOwner=4'b0001, oPO_DQStrobe=iPO_DQStrobe[7:0], single oDone pulse, then READY.
REQ-034 SHALL cover back-to-back: step 2 with iCMDValid/iCMDStep=3 held during iStepLast[2] -> oStart=4'b1000 on the next cycle, no idle cycle.
REQ-035 SHALL cover timeout: TIMEOUT_CYCLES=16, iStepLast held 0 -> oTimeout pulse after 16 RUN cycles, outputs at idle, oCMDReady=1 the next cycle.
REQ-036 SHALL cover foreign completion: iStepLast[1]=1 while rSel=2 -> no oDone, FSM stays in RUN.
REQ-037 SHALL cover mid-step reset: iReset pulsed while in RUN of step 3 -> all outputs at reset values at once; a new request is accepted only after REQ-032 timing.
REQ-038 SHALL cover coincidence: iStepLast[rSel] in the same cycle the timer reaches TIMEOUT_CYCLES -> oDone=1, oTimeout=0.

Source files
------------

// File: rtl/npm_toggle_phy_step_arbiter.sv
// Step arbiter for the NAND toggle PHY: it grants one step primitive at a time and muxes
// that step's PHY controls onto the shared outputs, with a bounded run time per step.
module npm_toggle_phy_step_arbiter #(
    parameter logic [9:0] TIMEOUT_CYCLES = 10'd1023
) (
    input  logic        iSystemClock,
    input  logic        iReset,
    input  logic        iCMDValid,
    input  logic [1:0]  iCMDStep,
    output logic        oCMDReady,
    output logic [3:0]  oStart,
    input  logic [3:0]  iStepLast,
    input  logic [3:0]  iPI_BUFF_Reset,
    input  logic [3:0]  iPI_BUFF_RE,
    input  logic [3:0]  iPI_BUFF_WE,
    input  logic [3:0]  iDQSOutEnable,
    input  logic [31:0] iPO_DQStrobe,
    output logic        oPI_BUFF_Reset,
    output logic        oPI_BUFF_RE,
    output logic        oPI_BUFF_WE,
    output logic        oDQSOutEnable,
    output logic [7:0]  oPO_DQStrobe,
    output logic [3:0]  oOwner,
    output logic        oDone,
    output logic        oTimeout
);

    typedef enum logic [4:0] {
        S_RESET = 5'b00001,
        S_READY = 5'b00010,
        S_START = 5'b00100,
        S_RUN   = 5'b01000,
        S_ABORT = 5'b10000
    } state_t;

    localparam logic [9:0] LP_LAST_RUN = TIMEOUT_CYCLES - 10'd1;

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_sel;
    logic [1:0] w_sel_next;
    logic [9:0] r_timer;
    logic [9:0] w_timer_next;

    logic [3:0] w_onehot;
    logic       w_last;
    logic       w_expire;
    logic       w_active;
    logic       w_cmd_ready;
    logic [3:0] w_start;
    logic       w_done;
    logic       w_tmo;

    assign w_onehot = 4'b0001 << r_sel;
    assign w_last   = iStepLast[r_sel];
    // r_timer counts RUN cycles already spent, so this is the last permitted RUN cycle.
    assign w_expire = (r_timer >= LP_LAST_RUN);

    always_ff @(posedge iSystemClock or posedge iReset) begin
        if (iReset) begin
            r_state <= S_RESET;
            r_sel   <= 2'd0;
            r_timer <= 10'd0;
        end else begin
            r_state <= w_state_next;
            r_sel   <= w_sel_next;
            r_timer <= w_timer_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_timer_next = r_timer;
        w_cmd_ready  = 1'b0;
        w_start      = 4'b0000;
        w_done       = 1'b0;
        w_tmo        = 1'b0;
        w_active     = 1'b0;
        case (r_state)
            S_RESET: begin
                w_state_next = S_READY;
            end
            S_READY: begin
                w_cmd_ready = 1'b1;
                if (iCMDValid) begin
                    w_sel_next   = iCMDStep;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_active     = 1'b1;
                w_start      = w_onehot;
                w_timer_next = 10'd0;
                w_state_next = S_RUN;
            end
            S_RUN: begin
                w_active     = 1'b1;
                w_timer_next = (r_timer == TIMEOUT_CYCLES) ? r_timer : r_timer + 10'd1;
                // Completion wins over a coinciding timeout.
                if (w_last) begin
                    w_done      = 1'b1;
                    w_cmd_ready = 1'b1;
                    if (iCMDValid) begin
                        w_sel_next   = iCMDStep;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_READY;
                    end
                end else if (w_expire) begin
                    w_state_next = S_ABORT;
                end
            end
            S_ABORT: begin
                w_tmo        = 1'b1;
                w_state_next = S_READY;
            end
            default: begin
                w_state_next = S_RESET;
            end
        endcase
    end

    // Outputs drop to zero the moment reset asserts, not at the next edge.
    always_comb begin
        oStart         = 4'b0000;
        oCMDReady      = 1'b0;
        oDone          = 1'b0;
        oTimeout       = 1'b0;
        oOwner         = 4'b0000;
        oPI_BUFF_Reset = 1'b0;
        oPI_BUFF_RE    = 1'b0;
        oPI_BUFF_WE    = 1'b0;
        oDQSOutEnable  = 1'b0;
        oPO_DQStrobe   = 8'h00;
        if (!iReset) begin
            oStart        = w_start;
            oCMDReady     = w_cmd_ready;
            oDone         = w_done;
            oTimeout      = w_tmo;
            oDQSOutEnable = 1'b1;
            if (w_active) begin
                oOwner         = w_onehot;
                oPI_BUFF_Reset = iPI_BUFF_Reset[r_sel];
                oPI_BUFF_RE    = iPI_BUFF_RE[r_sel];
                oPI_BUFF_WE    = iPI_BUFF_WE[r_sel];
                oDQSOutEnable  = iDQSOutEnable[r_sel];
                oPO_DQStrobe   = iPO_DQStrobe[{r_sel, 3'b000} +: 8];
            end
        end
    end

endmodule

// File: tb/tb_npm_toggle_phy_step_arbiter.sv
// Bench for the step arbiter: a default-timeout instance for normal steps and a short-timeout
// instance sharing the same inputs for the abort and coincidence cases.
module tb_npm_toggle_phy_step_arbiter;

    logic        iSystemClock = 1'b0;
    logic        iReset;
    logic        iCMDValid;
    logic [1:0]  iCMDStep;
    logic [3:0]  iStepLast;
    logic [3:0]  iPI_BUFF_Reset, iPI_BUFF_RE, iPI_BUFF_WE, iDQSOutEnable;
    logic [31:0] iPO_DQStrobe;

    logic        oCMDReady, oPI_BUFF_Reset, oPI_BUFF_RE, oPI_BUFF_WE, oDQSOutEnable, oDone, oTimeout;
    logic [3:0]  oStart, oOwner;
    logic [7:0]  oPO_DQStrobe;

    logic        t_oCMDReady, t_oPI_BUFF_Reset, t_oPI_BUFF_RE, t_oPI_BUFF_WE, t_oDQSOutEnable, t_oDone, t_oTimeout;
    logic [3:0]  t_oStart, t_oOwner;
    logic [7:0]  t_oPO_DQStrobe;

    npm_toggle_phy_step_arbiter dut (
        .iSystemClock(iSystemClock), .iReset(iReset), .iCMDValid(iCMDValid), .iCMDStep(iCMDStep),
        .oCMDReady(oCMDReady), .oStart(oStart), .iStepLast(iStepLast),
        .iPI_BUFF_Reset(iPI_BUFF_Reset), .iPI_BUFF_RE(iPI_BUFF_RE), .iPI_BUFF_WE(iPI_BUFF_WE),
        .iDQSOutEnable(iDQSOutEnable), .iPO_DQStrobe(iPO_DQStrobe),
        .oPI_BUFF_Reset(oPI_BUFF_Reset), .oPI_BUFF_RE(oPI_BUFF_RE), .oPI_BUFF_WE(oPI_BUFF_WE),
        .oDQSOutEnable(oDQSOutEnable), .oPO_DQStrobe(oPO_DQStrobe), .oOwner(oOwner),
        .oDone(oDone), .oTimeout(oTimeout)
    );

    npm_toggle_phy_step_arbiter #(.TIMEOUT_CYCLES(10'd16)) dut_t (
        .iSystemClock(iSystemClock), .iReset(iReset), .iCMDValid(iCMDValid), .iCMDStep(iCMDStep),
        .oCMDReady(t_oCMDReady), .oStart(t_oStart), .iStepLast(iStepLast),
        .iPI_BUFF_Reset(iPI_BUFF_Reset), .iPI_BUFF_RE(iPI_BUFF_RE), .iPI_BUFF_WE(iPI_BUFF_WE),
        .iDQSOutEnable(iDQSOutEnable), .iPO_DQStrobe(iPO_DQStrobe),
        .oPI_BUFF_Reset(t_oPI_BUFF_Reset), .oPI_BUFF_RE(t_oPI_BUFF_RE), .oPI_BUFF_WE(t_oPI_BUFF_WE),
        .oDQSOutEnable(t_oDQSOutEnable), .oPO_DQStrobe(t_oPO_DQStrobe), .oOwner(t_oOwner),
        .oDone(t_oDone), .oTimeout(t_oTimeout)
    );

    always #5 iSystemClock = ~iSystemClock;

    typedef struct {
        logic [3:0] start;
        logic       to;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic tick();
        @(negedge iSystemClock);
    endtask

    task automatic issue(input logic [1:0] step);
        exp_t e;
        iCMDValid = 1'b1;
        iCMDStep  = step;
        e.start   = 4'b0001 << step;
        e.to      = 1'b0;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        iReset = 1'b1; iCMDValid = 1'b0; iCMDStep = 2'd0; iStepLast = 4'h0;
        iPI_BUFF_Reset = 4'hF; iPI_BUFF_RE = 4'hF; iPI_BUFF_WE = 4'hF; iDQSOutEnable = 4'hF;
        iPO_DQStrobe = 32'hFFFF_FFFF;
        repeat (2) tick();
        #1;
        checks++;
        if ({oStart, oCMDReady, oDone, oTimeout, oOwner, oPI_BUFF_Reset, oPI_BUFF_RE, oPI_BUFF_WE,
             oDQSOutEnable, oPO_DQStrobe} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got start=%b rdy=%b own=%b dqs_oe=%b strobe=%h want all zero",
                     oStart, oCMDReady, oOwner, oDQSOutEnable, oPO_DQStrobe);
        end
        tick();
        iReset = 1'b0;
        #1;
        checks++;
        if (oCMDReady !== 1'b0 || oDQSOutEnable !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b dqs_oe=%b want rdy=0 dqs_oe=1", oCMDReady, oDQSOutEnable);
        end
        tick();
        #1;
        checks++;
        if (oCMDReady !== 1'b1 || oOwner !== 4'h0) begin
            errors++;
            $display("FAIL ready_after_reset: got rdy=%b own=%b want rdy=1 own=0000", oCMDReady, oOwner);
        end
    endtask

    task automatic test_single_step();
        int   bad;
        exp_t e;
        iPO_DQStrobe = $urandom();
        tick();
        issue(2'd0);
        tick();
        iCMDValid = 1'b0;
        #1;
        checks++;
        if (sb.size() == 0 || oStart !== sb[0].start || oOwner !== 4'b0001 ||
            oPO_DQStrobe !== iPO_DQStrobe[7:0] || oCMDReady !== 1'b0) begin
            errors++;
            $display("FAIL single_start: got start=%b own=%b strobe=%h rdy=%b want start=0001 own=0001 strobe=%h rdy=0",
                     oStart, oOwner, oPO_DQStrobe, oCMDReady, iPO_DQStrobe[7:0]);
        end
        bad = 0;
        for (int i = 1; i < 64; i++) begin
            tick();
            #1;
            if (oStart !== 4'h0 || oDone !== 1'b0 || oOwner !== 4'b0001 || oCMDReady !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL single_run_quiet: got %0d bad RUN cycles want 0", bad);
        end
        tick();
        iStepLast = 4'b0001;
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL single_done: scoreboard empty, done=%b want an expected entry", oDone);
        end else begin
            e = sb.pop_front();
            if ({oDone, oTimeout, oCMDReady} !== {~e.to, e.to, 1'b1}) begin
                errors++;
                $display("FAIL single_done: got done=%b tmo=%b rdy=%b want done=1 tmo=0 rdy=1",
                         oDone, oTimeout, oCMDReady);
            end
        end
        tick();
        iStepLast = 4'h0;
        #1;
        checks++;
        if (oDone !== 1'b0 || oOwner !== 4'h0 || oCMDReady !== 1'b1) begin
            errors++;
            $display("FAIL single_back_to_ready: got done=%b own=%b rdy=%b want 0 0000 1", oDone, oOwner, oCMDReady);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        tick();
        issue(2'd2);
        tick();
        iCMDValid = 1'b0;
        #1;
        checks++;
        if (sb.size() == 0 || oStart !== sb[0].start) begin
            errors++;
            $display("FAIL b2b_first_start: got start=%b want 0100", oStart);
        end
        repeat (5) tick();
        iStepLast = 4'b0100;
        issue(2'd3);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL b2b_first_done: scoreboard empty, done=%b", oDone);
        end else begin
            e = sb.pop_front();
            if (oDone !== ~e.to || oCMDReady !== 1'b1 || oOwner !== e.start) begin
                errors++;
                $display("FAIL b2b_first_done: got done=%b rdy=%b own=%b want done=1 rdy=1 own=%b",
                         oDone, oCMDReady, oOwner, e.start);
            end
        end
        tick();
        iStepLast = 4'h0;
        iCMDValid = 1'b0;
        #1;
        checks++;
        if (sb.size() == 0 || oStart !== sb[0].start || oOwner !== 4'b1000 || oDone !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_start: got start=%b own=%b done=%b want start=1000 own=1000 done=0",
                     oStart, oOwner, oDone);
        end
        repeat (2) tick();
        iStepLast = 4'b1000;
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL b2b_second_done: scoreboard empty, done=%b", oDone);
        end else begin
            e = sb.pop_front();
            if (oDone !== ~e.to) begin
                errors++;
                $display("FAIL b2b_second_done: got done=%b want 1", oDone);
            end
        end
        tick();
        iStepLast = 4'h0;
    endtask

    task automatic test_foreign_completion();
        int   bad;
        exp_t e;
        iPO_DQStrobe = $urandom();
        iPI_BUFF_Reset = 4'b1011; iPI_BUFF_RE = 4'b0100; iPI_BUFF_WE = 4'b1011; iDQSOutEnable = 4'b1011;
        tick();
        issue(2'd2);
        tick();
        iCMDValid = 1'b0;
        #1;
        checks++;
        if (sb.size() == 0 || oStart !== sb[0].start) begin
            errors++;
            $display("FAIL foreign_start: got start=%b want 0100", oStart);
        end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            iStepLast = 4'b1011;
            #1;
            if (oDone !== 1'b0 || oOwner !== 4'b0100 || oPO_DQStrobe !== iPO_DQStrobe[23:16] ||
                {oPI_BUFF_Reset, oPI_BUFF_RE, oPI_BUFF_WE, oDQSOutEnable} !== 4'b0100) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL foreign_ignored: got %0d bad cycles want 0 (done=%b own=%b strobe=%h want %h)",
                     bad, oDone, oOwner, oPO_DQStrobe, iPO_DQStrobe[23:16]);
        end
        tick();
        iStepLast = 4'b0100;
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL foreign_own_done: scoreboard empty, done=%b", oDone);
        end else begin
            e = sb.pop_front();
            if (oDone !== ~e.to) begin
                errors++;
                $display("FAIL foreign_own_done: got done=%b want 1", oDone);
            end
        end
        tick();
        iStepLast = 4'h0;
    endtask

    task automatic test_timeout();
        int   bad;
        exp_t e;
        iDQSOutEnable = 4'b0000;
        iPO_DQStrobe = 32'hA5A5_A5A5;
        tick();
        issue(2'd1);
        tick();
        iCMDValid = 1'b0;
        #1;
        checks++;
        if (sb.size() == 0 || oStart !== sb[0].start || t_oStart !== 4'b0010) begin
            errors++;
            $display("FAIL timeout_start: got start=%b t_start=%b want 0010", oStart, t_oStart);
        end
        bad = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            #1;
            if (t_oTimeout !== 1'b0 || t_oOwner !== 4'b0010) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_run_quiet: got %0d bad RUN cycles want 0", bad);
        end
        tick();
        #1;
        checks++;
        if (t_oTimeout !== 1'b1 || t_oOwner !== 4'h0 || t_oDQSOutEnable !== 1'b1 || t_oPO_DQStrobe !== 8'h00 ||
            t_oCMDReady !== 1'b0 || {t_oPI_BUFF_Reset, t_oPI_BUFF_RE, t_oPI_BUFF_WE} !== 3'b000) begin
            errors++;
            $display("FAIL timeout_abort: got tmo=%b own=%b dqs_oe=%b strobe=%h rdy=%b want 1 0000 1 00 0",
                     t_oTimeout, t_oOwner, t_oDQSOutEnable, t_oPO_DQStrobe, t_oCMDReady);
        end
        tick();
        #1;
        checks++;
        if (t_oTimeout !== 1'b0 || t_oCMDReady !== 1'b1) begin
            errors++;
            $display("FAIL timeout_ready: got tmo=%b rdy=%b want tmo=0 rdy=1", t_oTimeout, t_oCMDReady);
        end
        checks++;
        if (oOwner !== 4'b0010 || oTimeout !== 1'b0 || oDone !== 1'b0) begin
            errors++;
            $display("FAIL long_timeout_still_run: got own=%b tmo=%b done=%b want 0010 0 0", oOwner, oTimeout, oDone);
        end
        tick();
        iStepLast = 4'b0010;
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL timeout_main_done: scoreboard empty, done=%b", oDone);
        end else begin
            e = sb.pop_front();
            if (oDone !== ~e.to) begin
                errors++;
                $display("FAIL timeout_main_done: got done=%b want 1", oDone);
            end
        end
        tick();
        iStepLast = 4'h0;
    endtask

    task automatic test_coincidence();
        exp_t e;
        tick();
        issue(2'd0);
        tick();
        iCMDValid = 1'b0;
        #1;
        checks++;
        if (sb.size() == 0 || oStart !== sb[0].start || t_oStart !== 4'b0001) begin
            errors++;
            $display("FAIL coinc_start: got start=%b t_start=%b want 0001", oStart, t_oStart);
        end
        repeat (15) tick();
        tick();
        iStepLast = 4'b0001;
        #1;
        checks++;
        if (t_oDone !== 1'b1 || t_oTimeout !== 1'b0 || t_oCMDReady !== 1'b1) begin
            errors++;
            $display("FAIL coinc_done: got done=%b tmo=%b rdy=%b want 1 0 1", t_oDone, t_oTimeout, t_oCMDReady);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL coinc_main_done: scoreboard empty, done=%b", oDone);
        end else begin
            e = sb.pop_front();
            if (oDone !== ~e.to) begin
                errors++;
                $display("FAIL coinc_main_done: got done=%b want 1", oDone);
            end
        end
        tick();
        iStepLast = 4'h0;
        #1;
        checks++;
        if (t_oTimeout !== 1'b0 || t_oCMDReady !== 1'b1 || t_oOwner !== 4'h0) begin
            errors++;
            $display("FAIL coinc_no_abort: got tmo=%b rdy=%b own=%b want 0 1 0000", t_oTimeout, t_oCMDReady, t_oOwner);
        end
    endtask

    task automatic test_mid_step_reset();
        exp_t e;
        iDQSOutEnable = 4'hF;
        iPO_DQStrobe = 32'hFFFF_FFFF;
        tick();
        issue(2'd3);
        tick();
        iCMDValid = 1'b0;
        #1;
        checks++;
        if (sb.size() == 0 || oStart !== sb[0].start) begin
            errors++;
            $display("FAIL midrst_start: got start=%b want 1000", oStart);
        end
        repeat (3) tick();
        #1;
        checks++;
        if (oOwner !== 4'b1000 || oDQSOutEnable !== 1'b1) begin
            errors++;
            $display("FAIL midrst_running: got own=%b dqs_oe=%b want 1000 1", oOwner, oDQSOutEnable);
        end
        #1;
        iReset = 1'b1;
        #1;
        checks++;
        if ({oStart, oCMDReady, oDone, oTimeout, oOwner, oPI_BUFF_Reset, oPI_BUFF_RE, oPI_BUFF_WE,
             oDQSOutEnable, oPO_DQStrobe} !== 25'd0) begin
            errors++;
            $display("FAIL midrst_immediate: got start=%b rdy=%b own=%b dqs_oe=%b strobe=%h want all zero",
                     oStart, oCMDReady, oOwner, oDQSOutEnable, oPO_DQStrobe);
        end
        sb.delete();
        repeat (2) tick();
        iReset = 1'b0;
        issue(2'd3);
        #1;
        checks++;
        if (oCMDReady !== 1'b0 || oStart !== 4'h0) begin
            errors++;
            $display("FAIL midrst_first_cycle: got rdy=%b start=%b want 0 0000", oCMDReady, oStart);
        end
        tick();
        #1;
        checks++;
        if (oCMDReady !== 1'b1 || oStart !== 4'h0) begin
            errors++;
            $display("FAIL midrst_ready: got rdy=%b start=%b want 1 0000", oCMDReady, oStart);
        end
        tick();
        iCMDValid = 1'b0;
        #1;
        checks++;
        if (sb.size() == 0 || oStart !== sb[0].start) begin
            errors++;
            $display("FAIL midrst_restart: got start=%b want 1000", oStart);
        end
        repeat (2) tick();
        iStepLast = 4'b1000;
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL midrst_done: scoreboard empty, done=%b", oDone);
        end else begin
            e = sb.pop_front();
            if (oDone !== ~e.to) begin
                errors++;
                $display("FAIL midrst_done: got done=%b want 1", oDone);
            end
        end
        tick();
        iStepLast = 4'h0;
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_back_to_back();
        test_foreign_completion();
        test_timeout();
        test_coincidence();
        test_mid_step_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained: got %0d entries left want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
